// File: rtl/tdm_mux_pkg.sv
// Shared types and helpers for the tdm_mux channel multiplexer.
package tdm_mux_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    localparam int unsigned LEAF   = 4;
    localparam int unsigned MAX_CH = 256;
    localparam int unsigned IDX_W  = 8;

    typedef struct packed {
        logic             any;
        logic             wrap;
        logic [IDX_W-1:0] idx;
    } next_t;

    // Lowest enabled index above cur; falls back to the lowest enabled index overall (wrap).
    function automatic next_t next_enabled(input logic [MAX_CH-1:0] mask,
                                           input int unsigned        cur,
                                           input int unsigned        n_ch);
        next_t            r;
        logic             found_up;
        logic [IDX_W-1:0] idx_up;
        r        = '0;
        found_up = 1'b0;
        idx_up   = '0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            if (i < n_ch && mask[i]) begin
                if (!r.any) begin
                    r.any = 1'b1;
                    r.idx = IDX_W'(i);
                end
                if (i > cur && !found_up) begin
                    found_up = 1'b1;
                    idx_up   = IDX_W'(i);
                end
            end
        end
        r.wrap = !found_up;
        if (found_up) r.idx = idx_up;
        return r;
    endfunction

endpackage

// File: rtl/tdm_mux_mux4_w.sv
// W-bit 4:1 leaf multiplexer used to build the channel select tree.
module mux4_w
    import tdm_mux_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic [LEAF*W-1:0] d,
    input  logic [1:0]        s,
    output logic [W-1:0]      y
);

    assign y = d[32'(s)*W +: W];

endmodule

// File: rtl/tdm_mux.sv
// Registered N:1 channel mux with direct-select handshake and masked round-robin scan.
// Define TDM_MUX_PIPE_EN to register the leaf level of the select tree (one extra cycle).
module tdm_mux
    import tdm_mux_pkg::*;
#(
    parameter int unsigned N_CH  = 16,
    parameter int unsigned W     = 1,
    parameter int unsigned DWELL = 1,
    parameter int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] din,
    input  logic              mode,
    input  logic [N_CH-1:0]   en_mask,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic              sel_valid,
    output logic              sel_ready,
    output logic [W-1:0]      dout,
    output logic [SEL_W-1:0]  dout_ch,
    output logic              dout_valid,
    output logic              scan_wrap
);

    localparam int unsigned DW_W   = $clog2(DWELL + 1);
    localparam int unsigned N_LEAF = N_CH / LEAF;
    localparam int unsigned LV     = (SEL_W - 1) / 2;
    localparam int unsigned UP_PAD = 1 << (2 * LV);
    localparam int unsigned UP_W   = UP_PAD * W;
    localparam int unsigned US_W   = (LV == 0) ? 1 : 2 * LV;

    logic [SEL_W-1:0] cur_sel, sel_d;
    logic [DW_W-1:0]  dwell_cnt, dwell_d;
    logic             wrap_pend, wrap_d;
    logic             nx_any, nx_wrap;
    logic [IDX_W-1:0] nx_idx;

    assign sel_ready = ~mode;

    // Select/scan sequencing
    always_comb begin
        sel_d   = cur_sel;
        dwell_d = dwell_cnt;
        wrap_d  = 1'b0;
        {nx_any, nx_wrap, nx_idx} = next_enabled(MAX_CH'(en_mask), 32'(cur_sel), N_CH);
        if (mode_e'(mode) == MODE_DIRECT) begin
            dwell_d = '0;
            if (sel_valid) sel_d = sel_in;
        end else if (nx_any) begin
            if (!en_mask[cur_sel] || dwell_cnt == DW_W'(DWELL - 1)) begin
                sel_d   = SEL_W'(nx_idx);
                dwell_d = '0;
                wrap_d  = nx_wrap;
            end else begin
                dwell_d = dwell_cnt + DW_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_sel   <= '0;
            dwell_cnt <= '0;
            wrap_pend <= 1'b0;
        end else begin
            cur_sel   <= sel_d;
            dwell_cnt <= dwell_d;
            wrap_pend <= wrap_d;
        end
    end

    // Leaf level of the select tree
    logic [N_LEAF*W-1:0] leaf_y;
    for (genvar g = 0; g < N_LEAF; g++) begin : g_leaf
        mux4_w #(.W(W)) u_leaf (
            .d(din[g*LEAF*W +: LEAF*W]),
            .s(cur_sel[1:0]),
            .y(leaf_y[g*W +: W])
        );
    end

    logic [N_LEAF*W-1:0] leaf_a;
    logic [SEL_W-1:0]    sel_a;
    logic                valid_a;
    logic                wrap_a;

`ifdef TDM_MUX_PIPE_EN
    // Split point: leaf results and their tag/valid/wrap travel together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leaf_a  <= '0;
            sel_a   <= '0;
            valid_a <= 1'b0;
            wrap_a  <= 1'b0;
        end else begin
            leaf_a  <= leaf_y;
            sel_a   <= cur_sel;
            valid_a <= en_mask[cur_sel];
            wrap_a  <= wrap_pend;
        end
    end
`else
    assign leaf_a  = leaf_y;
    assign sel_a   = cur_sel;
    assign valid_a = en_mask[cur_sel];
    assign wrap_a  = wrap_pend;
`endif

    // Upper tree; leaf count is zero-padded to a power of four
    logic [UP_W-1:0] up_in;
    logic [US_W-1:0] up_s;
    logic [W-1:0]    up_y;

    assign up_in = UP_W'(leaf_a);
    assign up_s  = US_W'(sel_a >> 2);

    for (genvar l = 0; l < LV; l++) begin : g_lvl
        localparam int unsigned NO = 1 << (2 * (LV - 1 - l));
        logic [NO*W-1:0] y;
        for (genvar j = 0; j < NO; j++) begin : g_m
            if (l == 0) begin : g_first
                mux4_w #(.W(W)) u_m (
                    .d(up_in[j*LEAF*W +: LEAF*W]),
                    .s(up_s[2*l +: 2]),
                    .y(y[j*W +: W])
                );
            end else begin : g_next
                mux4_w #(.W(W)) u_m (
                    .d(g_lvl[l-1].y[j*LEAF*W +: LEAF*W]),
                    .s(up_s[2*l +: 2]),
                    .y(y[j*W +: W])
                );
            end
        end
    end

    if (LV == 0) begin : g_root_leaf
        assign up_y = up_in[W-1:0] | {W{up_s[0] & 1'b0}};
    end else begin : g_root_tree
        assign up_y = g_lvl[LV-1].y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
            scan_wrap  <= 1'b0;
        end else begin
            dout       <= up_y;
            dout_ch    <= sel_a;
            dout_valid <= valid_a;
            scan_wrap  <= wrap_a;
        end
    end

endmodule

// File: tb/tb_tdm_mux.sv
// Self-checking bench for tdm_mux: table of per-cycle vectors plus reset-in-scan sequence.
module tb_tdm_mux;

    localparam int unsigned N_CH  = 16;
    localparam int unsigned W     = 8;
    localparam int unsigned DWELL = 2;
    localparam int unsigned SEL_W = 4;
`ifdef TDM_MUX_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk;
    logic              rst;
    logic [N_CH*W-1:0] din;
    logic              mode;
    logic [N_CH-1:0]   en_mask;
    logic [SEL_W-1:0]  sel_in;
    logic              sel_valid;
    logic              sel_ready;
    logic [W-1:0]      dout;
    logic [SEL_W-1:0]  dout_ch;
    logic              dout_valid;
    logic              scan_wrap;

    tdm_mux #(.N_CH(N_CH), .W(W), .DWELL(DWELL)) dut (
        .clk(clk), .rst(rst), .din(din), .mode(mode), .en_mask(en_mask),
        .sel_in(sel_in), .sel_valid(sel_valid), .sel_ready(sel_ready),
        .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid), .scan_wrap(scan_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [15:0] mask;
        logic        sv;
        logic [3:0]  sel;
        logic [3:0]  ch;
        logic        vld;
        logic        wrap;
    } row_t;

    typedef struct {
        logic [7:0] dout;
        logic [3:0] ch;
        logic       vld;
        logic       wrap;
    } exp_t;

    exp_t q[$];
    row_t tbl[32];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic row_t mk(input logic m, input logic [15:0] msk, input logic sv,
                                input logic [3:0] sel, input logic [3:0] ch,
                                input logic v, input logic w);
        row_t r;
        r.mode = m; r.mask = msk; r.sv = sv; r.sel = sel;
        r.ch = ch; r.vld = v; r.wrap = w;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input exp_t e, input string tag);
        chk({tag, " dout"},       32'(dout),       32'(e.dout));
        chk({tag, " dout_ch"},    32'(dout_ch),    32'(e.ch));
        chk({tag, " dout_valid"}, 32'(dout_valid), 32'(e.vld));
        chk({tag, " scan_wrap"},  32'(scan_wrap),  32'(e.wrap));
    endtask

    task automatic prefill();
        exp_t z;
        z.dout = '0; z.ch = '0; z.vld = 1'b0; z.wrap = 1'b0;
        q.delete();
        repeat (LAT - 1) q.push_back(z);
    endtask

    // Drive one cycle of stimulus; expected output for this cycle goes to the scoreboard
    task automatic step(input row_t r, input string tag);
        exp_t e;
        mode      = r.mode;
        en_mask   = r.mask;
        sel_valid = r.sv;
        sel_in    = r.sel;
        #1;
        chk({tag, " sel_ready"}, 32'(sel_ready), 32'(!r.mode));
        e.dout = 8'(32'(r.ch) * 17);
        e.ch   = r.ch;
        e.vld  = r.vld;
        e.wrap = r.wrap;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (q.size() >= LAT) check_out(q.pop_front(), tag);
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            check_out(q.pop_front(), tag);
        end
    endtask

    task automatic check_zero(input string tag);
        exp_t z;
        z.dout = '0; z.ch = '0; z.vld = 1'b0; z.wrap = 1'b0;
        check_out(z, tag);
    endtask

    initial begin
        for (int i = 0; i < int'(N_CH); i++) din[i*W +: W] = 8'(i * 17);
        rst = 1'b1; mode = 1'b0; en_mask = '0; sel_valid = 1'b0; sel_in = '0;

        //           mode mask      sv sel  ch vld wrap
        tbl[0]  = mk(0, 16'hFFFF, 1, 5,  0, 1, 0);
        tbl[1]  = mk(0, 16'hFFFF, 0, 0,  5, 1, 0);
        tbl[2]  = mk(0, 16'hFDFF, 1, 9,  5, 1, 0);
        tbl[3]  = mk(0, 16'hFDFF, 0, 0,  9, 0, 0);
        tbl[4]  = mk(0, 16'h000B, 1, 0,  9, 0, 0);
        tbl[5]  = mk(1, 16'h000B, 0, 0,  0, 1, 0);
        tbl[6]  = mk(1, 16'h000B, 0, 0,  0, 1, 0);
        tbl[7]  = mk(1, 16'h000B, 0, 0,  1, 1, 0);
        tbl[8]  = mk(1, 16'h000B, 0, 0,  1, 1, 0);
        tbl[9]  = mk(1, 16'h000B, 0, 0,  3, 1, 0);
        tbl[10] = mk(1, 16'h000B, 0, 0,  3, 1, 0);
        tbl[11] = mk(1, 16'h000B, 0, 0,  0, 1, 1);
        tbl[12] = mk(1, 16'h000B, 0, 0,  0, 1, 0);
        tbl[13] = mk(1, 16'h000B, 1, 9,  1, 1, 0);
        tbl[14] = mk(1, 16'h000B, 1, 9,  1, 1, 0);
        tbl[15] = mk(1, 16'h000B, 0, 0,  3, 1, 0);
        tbl[16] = mk(1, 16'h0000, 0, 0,  3, 0, 0);
        tbl[17] = mk(1, 16'h0000, 0, 0,  3, 0, 0);
        tbl[18] = mk(1, 16'h000B, 0, 0,  3, 1, 0);
        tbl[19] = mk(1, 16'h000B, 0, 0,  0, 1, 1);
        tbl[20] = mk(1, 16'h000B, 0, 0,  0, 1, 0);
        tbl[21] = mk(1, 16'h000B, 0, 0,  1, 1, 0);
        tbl[22] = mk(1, 16'h0001, 0, 0,  1, 0, 0);
        tbl[23] = mk(1, 16'h0001, 0, 0,  0, 1, 1);
        tbl[24] = mk(1, 16'h0001, 0, 0,  0, 1, 0);
        tbl[25] = mk(1, 16'h0001, 0, 0,  0, 1, 1);
        tbl[26] = mk(1, 16'h0001, 0, 0,  0, 1, 0);
        tbl[27] = mk(0, 16'h0001, 0, 0,  0, 1, 1);
        tbl[28] = mk(0, 16'h000B, 1, 3,  0, 1, 0);
        tbl[29] = mk(1, 16'h000B, 0, 0,  3, 1, 0);
        tbl[30] = mk(1, 16'h000B, 0, 0,  3, 1, 0);
        tbl[31] = mk(1, 16'h000B, 0, 0,  0, 1, 1);

        repeat (2) @(negedge clk);
        #1;
        check_zero("reset");

        rst = 1'b0;
        prefill();
        for (int i = 0; i < 32; i++) step(tbl[i], $sformatf("row%0d", i));
        drain("row_drain");

        // Reset asserted in scan with dwell_cnt=1 on channel 3, then restart at channel 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        prefill();
        step(mk(1, 16'h000B, 0, 0, 0, 1, 0), "pre0");
        step(mk(1, 16'h000B, 0, 0, 0, 1, 0), "pre1");
        step(mk(1, 16'h000B, 0, 0, 1, 1, 0), "pre2");
        step(mk(1, 16'h000B, 0, 0, 1, 1, 0), "pre3");
        step(mk(1, 16'h000B, 0, 0, 3, 1, 0), "pre4");
        rst = 1'b1;
        #1;
        check_zero("rst_mid");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        prefill();
        step(mk(1, 16'h000B, 0, 0, 0, 1, 0), "post0");
        step(mk(1, 16'h000B, 0, 0, 0, 1, 0), "post1");
        step(mk(1, 16'h000B, 0, 0, 1, 1, 0), "post2");
        drain("post_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
